// File: rtl/ila_pkg.sv
// Shared types and constants for the ILA capture sequencer.
// States, frame header default and command field positions.
package ila_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ARMED     = 3'd1;
  localparam state_t S_POST      = 3'd2;
  localparam state_t S_DONE      = 3'd3;
  localparam state_t S_SEND_HDR  = 3'd4;
  localparam state_t S_SEND_DATA = 3'd5;

  localparam logic [7:0] ILA_HDR = 8'hA5;

  localparam int CMD_W       = 4;
  localparam int CMD_DO_RST  = 3;
  localparam int CMD_START   = 2;
  localparam int CMD_FORCE   = 1;
  localparam int CMD_TRIG_EN = 0;

endpackage

// File: rtl/ila_sdp_ram.sv
// Simple dual-port sample buffer, DEPTH x DW.
// One write port, one registered read port (1-cycle latency).
module ila_sdp_ram
  import ila_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ila_capture_seq.sv
// ILA capture sequencer: circular capture around a trigger, then UART frame.
// ILA_FRAME_CHECKSUM_EN appends an 8-bit sum of all bytes after the header.
module ila_capture_seq
  import ila_pkg::*;
#(
  parameter int         DW  = 16,
  parameter int         AW  = 10,
  parameter logic [7:0] HDR = ILA_HDR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upload,
  input  logic [15:0]   end_cnt,
  input  logic          trig_en,
  input  logic          start,
  input  logic          force_start,
  input  logic          do_rst,
  input  logic [DW-1:0] probe,
  input  logic          trig_in,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          armed,
  output logic          triggered,
  output logic          done
);

`ifdef ILA_FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  localparam int BPS = DW / 8;
  localparam int BIW = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [AW:0]   FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] MAXP = '1;
  localparam logic [BIW-1:0] LASTB = BIW'(BPS - 1);

  state_t state;
  logic [CMD_W-1:0] cmd;
  logic [15:0] end_q;
  logic force_q;
  logic tren_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;
  logic [AW:0] fill;
  logic [AW:0] fill_nx;
  logic [AW:0] fetch_left;
  logic [15:0] n_q;
  logic [1:0] hdr_idx;
  logic [BIW-1:0] byte_idx;
  logic wbuf_vld;
  logic fin;
  logic [7:0] csum;
  logic [DW-1:0] rdata;

  logic cap;
  logic trig;
  logic rd_en;
  logic ld;
  logic [AW-1:0] pclamp;
  logic src_vld;
  logic src_last;
  logic src_sum;
  logic src_data;
  logic [7:0] src_byte;

  assign cmd = {do_rst, start, force_start, trig_en};
  assign cap = (state == S_ARMED) || (state == S_POST);
  assign trig = (tren_q & trig_in) | force_q;
  assign fill_nx = (fill == FULL) ? fill : fill + 1'b1;
  assign pclamp = (32'(end_q) > 32'(MAXP)) ? MAXP : AW'(end_q);

  assign rd_en = ((state == S_SEND_HDR) || (state == S_SEND_DATA))
              && (fetch_left != '0) && !wbuf_vld;

  assign armed = (state == S_ARMED);
  assign triggered = (state == S_POST);
  assign done = (state == S_DONE) || (state == S_SEND_HDR)
             || (state == S_SEND_DATA);

  ila_sdp_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (cap),
    .waddr(wr_ptr),
    .wdata(probe),
    .re   (rd_en),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // Next frame byte; data bytes only come from an already-fetched word
  always_comb begin
    src_vld  = 1'b0;
    src_last = 1'b0;
    src_sum  = 1'b0;
    src_data = 1'b0;
    src_byte = '0;
    unique case (1'b1)
      fin: ;
      state == S_SEND_HDR: begin
        src_vld = 1'b1;
        src_sum = (hdr_idx != 2'd0);
        unique case (hdr_idx)
          2'd0:    src_byte = HDR;
          2'd1:    src_byte = n_q[7:0];
          default: src_byte = n_q[15:8];
        endcase
      end
      state == S_SEND_DATA && wbuf_vld: begin
        src_vld  = 1'b1;
        src_sum  = 1'b1;
        src_data = 1'b1;
        src_byte = 8'(rdata >> {byte_idx, 3'b000});
        src_last = !CSUM && (byte_idx == LASTB) && (fetch_left == '0);
      end
      state == S_SEND_DATA && CSUM && (fetch_left == '0): begin
        src_vld  = 1'b1;
        src_byte = csum;
        src_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign ld = src_vld && (!tx_valid || tx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      end_q      <= '0;
      force_q    <= 1'b0;
      tren_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      fill       <= '0;
      fetch_left <= '0;
      n_q        <= '0;
      hdr_idx    <= '0;
      byte_idx   <= '0;
      wbuf_vld   <= 1'b0;
      fin        <= 1'b0;
      csum       <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
    end else if (upload && cmd[CMD_DO_RST]) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      fill       <= '0;
      fetch_left <= '0;
      hdr_idx    <= '0;
      byte_idx   <= '0;
      wbuf_vld   <= 1'b0;
      fin        <= 1'b0;
      csum       <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
    end else begin
      if (cap) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill_nx;
      end
      if (rd_en) begin
        rd_ptr     <= rd_ptr + 1'b1;
        fetch_left <= fetch_left - 1'b1;
        wbuf_vld   <= 1'b1;
      end
      if (ld) begin
        tx_valid <= 1'b1;
        tx_data  <= src_byte;
        fin      <= src_last;
        if (src_sum) csum <= csum + src_byte;
        if (state == S_SEND_HDR) hdr_idx <= hdr_idx + 1'b1;
        if (src_data) begin
          if (byte_idx == LASTB) begin
            byte_idx <= '0;
            wbuf_vld <= 1'b0;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (upload && cmd[CMD_START]) begin
            state   <= S_ARMED;
            wr_ptr  <= '0;
            fill    <= '0;
            end_q   <= end_cnt;
            force_q <= cmd[CMD_FORCE];
            tren_q  <= cmd[CMD_TRIG_EN];
          end
        end
        S_ARMED: begin
          if (trig) begin
            post_cnt <= pclamp;
            state    <= (pclamp == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == AW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          rd_ptr     <= (fill == FULL) ? wr_ptr : '0;
          fetch_left <= fill;
          n_q        <= 16'(fill);
          hdr_idx    <= '0;
          byte_idx   <= '0;
          wbuf_vld   <= 1'b0;
          fin        <= 1'b0;
          csum       <= '0;
          state      <= S_SEND_HDR;
        end
        S_SEND_HDR: begin
          if (ld && hdr_idx == 2'd2) state <= S_SEND_DATA;
        end
        S_SEND_DATA: begin
          if (fin && tx_valid && tx_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ila_capture_seq.sv
// Scoreboard bench for ila_capture_seq at AW=4, DW=16.
// Frames are predicted from the driven probe stream and trigger timing.
module tb_ila_capture_seq;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic upload = 1'b0;
  logic [15:0] end_cnt = '0;
  logic trig_en = 1'b0;
  logic start = 1'b0;
  logic force_start = 1'b0;
  logic do_rst = 1'b0;
  logic [DW-1:0] probe = '0;
  logic trig_in = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic armed;
  logic triggered;
  logic done;

  int checks = 0;
  int failures = 0;
  int popped = 0;
  logic [7:0] sb [$];
  bit bp = 1'b0;
  bit hold = 1'b0;
  bit chk_idle = 1'b0;
  bit frame_done = 1'b0;
  bit stall_prev = 1'b0;
  bit abort_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always #5 clk = ~clk;

  ila_capture_seq #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upload     (upload),
    .end_cnt    (end_cnt),
    .trig_en    (trig_en),
    .start      (start),
    .force_start(force_start),
    .do_rst     (do_rst),
    .probe      (probe),
    .trig_in    (trig_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = hold ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: transfers complete on the next rising edge
  initial forever begin
    logic [7:0] exp;
    @(negedge clk);
    if (chk_idle) begin
      check("done_fall", 32'(done), 0);
      check("txv_after_last", 32'(tx_valid), 0);
      chk_idle = 1'b0;
      frame_done = 1'b1;
    end
    if (stall_prev && !abort_prev) begin
      check("stall_valid", 32'(tx_valid), 1);
      check("stall_data", 32'(tx_data), 32'(stall_data));
    end
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        popped++;
        check("tx_byte", 32'(tx_data), 32'(exp));
        if (sb.size() == 0) chk_idle = 1'b1;
      end
    end
    stall_prev = tx_valid && !tx_ready;
    stall_data = tx_data;
    abort_prev = upload && do_rst;
  end

  task automatic capture(int ec, bit fs, bit te, int t_at, int abort_at,
                         logic [15:0] base);
    int p;
    int w;
    int n;
    logic [15:0] n16;
    logic [15:0] v;
    logic [7:0] sum;
    p = (ec > DEPTH - 1) ? DEPTH - 1 : ec;
    w = t_at + p + 1;
    n = (w > DEPTH) ? DEPTH : w;
    frame_done = 1'b0;
    if (abort_at < 0) begin
      n16 = 16'(n);
      sb.push_back(8'hA5);
      sb.push_back(n16[7:0]);
      sb.push_back(n16[15:8]);
      sum = n16[7:0] + n16[15:8];
      for (int k = w - n; k < w; k++) begin
        v = base + 16'(k);
        sb.push_back(v[7:0]);
        sb.push_back(v[15:8]);
        sum = sum + v[7:0] + v[15:8];
      end
`ifdef ILA_FRAME_CHECKSUM_EN
      sb.push_back(sum);
`endif
    end
    upload = 1'b1;
    start = 1'b1;
    force_start = fs;
    trig_en = te;
    end_cnt = 16'(ec);
    @(posedge clk);
    #1;
    upload = 1'b0;
    start = 1'b0;
    check("armed", 32'(armed), 1);
    for (int i = 0; i < w + 4; i++) begin
      probe = base + 16'(i);
      trig_in = (i == t_at);
      if (i == abort_at) begin
        upload = 1'b1;
        do_rst = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        upload = 1'b0;
        do_rst = 1'b0;
        check("abort_post_armed", 32'(armed), 0);
        check("abort_post_trig", 32'(triggered), 0);
        check("abort_post_done", 32'(done), 0);
        check("abort_post_txv", 32'(tx_valid), 0);
        break;
      end
      if (i == t_at && p > 0) check("triggered", 32'(triggered), 1);
    end
    trig_in = 1'b0;
  endtask

  task automatic wait_frame(string tag);
    int k;
    k = 0;
    while (!frame_done && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(frame_done), 1);
    check("sb_drained", 32'(sb.size()), 0);
    frame_done = 1'b0;
  endtask

  task automatic abort_send();
    int p0;
    int k;
    p0 = popped;
    capture(15, 1'b1, 1'b0, 0, -1, 16'h8000);
    k = 0;
    while (popped < p0 + 8 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_send_reached", 32'(popped - p0 >= 8), 1);
    hold = 1'b1;
    upload = 1'b1;
    do_rst = 1'b1;
    @(posedge clk);
    #1;
    upload = 1'b0;
    do_rst = 1'b0;
    sb.delete();
    chk_idle = 1'b0;
    check("abort_send_txv", 32'(tx_valid), 0);
    check("abort_send_done", 32'(done), 0);
    hold = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_send_quiet", 32'(tx_valid), 0);
    check("abort_send_pop", 32'(popped - p0 < 12), 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txv", 32'(tx_valid), 0);
    check("rst_txd", 32'(tx_data), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_trig", 32'(triggered), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_txv", 32'(tx_valid), 0);
    check("idle_armed", 32'(armed), 0);

    capture(4, 1'b1, 1'b0, 0, -1, 16'h0100);
    wait_frame("force_frame");
    capture(0, 1'b1, 1'b0, 0, -1, 16'h2200);
    wait_frame("endcnt0_frame");
    capture(3, 1'b0, 1'b1, 40, -1, 16'h3000);
    wait_frame("wrap_frame");
    bp = 1'b1;
    capture(3, 1'b0, 1'b1, 40, -1, 16'h3000);
    wait_frame("bp_frame");
    bp = 1'b0;
    capture(16'hFFFF, 1'b1, 1'b0, 0, -1, 16'h4400);
    wait_frame("clamp_frame");
    capture(16'hFFFF, 1'b0, 1'b1, 5, -1, 16'h5500);
    wait_frame("clamp_wrap_frame");

    capture(10, 1'b0, 1'b1, 3, 6, 16'h6000);
    repeat (30) @(posedge clk);
    #1;
    check("abort_post_quiet", 32'(tx_valid), 0);
    abort_send();

    capture(2, 1'b1, 1'b0, 0, -1, 16'h7000);
    wait_frame("recover_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
